// File: rtl/rename_register_file.sv
// Architectural register file with rename table (value, busy, ROB tag per register).
// Combinational read ports see same-cycle commits and renames from older slots
// in the same bundle; state updates on the rising clock edge.
module rename_register_file #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NREG      = 32,
   parameter int unsigned ROB_WIDTH = 4,
   parameter int unsigned ISSUE_W   = 2,
   parameter int unsigned COMMIT_W  = 2,
   localparam int unsigned AW       = $clog2(NREG)
) (
   input  logic                          clockIn,
   input  logic                          resetIn,
   input  logic                          readyIn,
   input  logic                          clearIn,
   input  logic [ISSUE_W-1:0]            rdFlag,
   input  logic [ISSUE_W*AW-1:0]         rdAddr,
   input  logic [ISSUE_W*ROB_WIDTH-1:0]  rdDest,
   input  logic [ISSUE_W*AW-1:0]         rs1Addr,
   input  logic [ISSUE_W*AW-1:0]         rs2Addr,
   output logic [ISSUE_W*XLEN-1:0]       rs1Value,
   output logic [ISSUE_W*ROB_WIDTH-1:0]  rs1Rename,
   output logic [ISSUE_W-1:0]            rs1Busy,
   output logic [ISSUE_W*XLEN-1:0]       rs2Value,
   output logic [ISSUE_W*ROB_WIDTH-1:0]  rs2Rename,
   output logic [ISSUE_W-1:0]            rs2Busy,
   input  logic [COMMIT_W-1:0]           writeFlag,
   input  logic [COMMIT_W*ROB_WIDTH-1:0] robId,
   input  logic [COMMIT_W*AW-1:0]        writeAddr,
   input  logic [COMMIT_W*XLEN-1:0]      writeValue
);

   logic [XLEN-1:0]      regValue [NREG];
   logic                 regBusy  [NREG];
   logic [ROB_WIDTH-1:0] regTag   [NREG];

   // Read ports: stored state, then commit bypass, then older-slot renames in this bundle.
   always_comb begin
      logic [AW-1:0]        r;
      logic [XLEN-1:0]      v;
      logic                 b;
      logic [ROB_WIDTH-1:0] t;
      logic                 tagHit;
      rs1Value  = '0;
      rs1Rename = '0;
      rs1Busy   = '0;
      rs2Value  = '0;
      rs2Rename = '0;
      rs2Busy   = '0;
      r      = '0;
      v      = '0;
      b      = 1'b0;
      t      = '0;
      tagHit = 1'b0;
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         for (int unsigned s = 0; s < 2; s++) begin
            r = (s == 0) ? rs1Addr[i*AW +: AW] : rs2Addr[i*AW +: AW];
            v = regValue[r];
            b = regBusy[r];
            t = regTag[r];
            // A commit whose tag matches the pending producer resolves the source.
            tagHit = 1'b0;
            for (int unsigned j = 0; j < COMMIT_W; j++) begin
               if (writeFlag[j] && writeAddr[j*AW +: AW] == r && regBusy[r] &&
                   robId[j*ROB_WIDTH +: ROB_WIDTH] == regTag[r]) begin
                  tagHit = 1'b1;
                  v      = writeValue[j*XLEN +: XLEN];
                  b      = 1'b0;
               end
            end
            // Stale commits still forward their value, youngest port last.
            if (!tagHit) begin
               for (int unsigned j = 0; j < COMMIT_W; j++) begin
                  if (writeFlag[j] && writeAddr[j*AW +: AW] == r)
                     v = writeValue[j*XLEN +: XLEN];
               end
            end
            // Older slot renaming the same register makes the source depend on it.
            for (int unsigned k = 0; k < i; k++) begin
               if (rdFlag[k] && rdAddr[k*AW +: AW] == r && r != '0) begin
                  b = 1'b1;
                  t = rdDest[k*ROB_WIDTH +: ROB_WIDTH];
               end
            end
            if (r == '0) begin
               v = '0;
               b = 1'b0;
               t = '0;
            end
            if (s == 0) begin
               rs1Value[i*XLEN +: XLEN]            = v;
               rs1Busy[i]                          = b;
               rs1Rename[i*ROB_WIDTH +: ROB_WIDTH] = t;
            end else begin
               rs2Value[i*XLEN +: XLEN]            = v;
               rs2Busy[i]                          = b;
               rs2Rename[i*ROB_WIDTH +: ROB_WIDTH] = t;
            end
         end
      end
   end

   // State update: flush clears busy only; otherwise commits then renames, later loop iterations win.
   always_ff @(posedge clockIn or negedge resetIn) begin
      if (!resetIn) begin
         for (int unsigned n = 0; n < NREG; n++) begin
            regValue[n] <= '0;
            regBusy[n]  <= 1'b0;
            regTag[n]   <= '0;
         end
      end else if (clearIn) begin
         for (int unsigned n = 0; n < NREG; n++)
            regBusy[n] <= 1'b0;
      end else if (readyIn) begin
         for (int unsigned j = 0; j < COMMIT_W; j++) begin
            if (writeFlag[j] && writeAddr[j*AW +: AW] != '0) begin
               regValue[writeAddr[j*AW +: AW]] <= writeValue[j*XLEN +: XLEN];
               if (regTag[writeAddr[j*AW +: AW]] == robId[j*ROB_WIDTH +: ROB_WIDTH])
                  regBusy[writeAddr[j*AW +: AW]] <= 1'b0;
            end
         end
         for (int unsigned k = 0; k < ISSUE_W; k++) begin
            if (rdFlag[k] && rdAddr[k*AW +: AW] != '0) begin
               regBusy[rdAddr[k*AW +: AW]] <= 1'b1;
               regTag[rdAddr[k*AW +: AW]]  <= rdDest[k*ROB_WIDTH +: ROB_WIDTH];
            end
         end
      end
   end

endmodule

// File: tb/tb_rename_register_file.sv
// Randomized and directed bench for rename_register_file against an array-based reference model.
module tb_rename_register_file;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int RW   = 4;
   localparam int IW   = 2;
   localparam int CW   = 2;
   localparam int AW   = 5;

   logic                clockIn = 1'b0;
   logic                resetIn, readyIn, clearIn;
   logic [IW-1:0]       rdFlag;
   logic [IW*AW-1:0]    rdAddr, rs1Addr, rs2Addr;
   logic [IW*RW-1:0]    rdDest, rs1Rename, rs2Rename;
   logic [IW*XLEN-1:0]  rs1Value, rs2Value;
   logic [IW-1:0]       rs1Busy, rs2Busy;
   logic [CW-1:0]       writeFlag;
   logic [CW*RW-1:0]    robId;
   logic [CW*AW-1:0]    writeAddr;
   logic [CW*XLEN-1:0]  writeValue;

   rename_register_file #(.XLEN(XLEN), .NREG(NREG), .ROB_WIDTH(RW), .ISSUE_W(IW), .COMMIT_W(CW)) dut (
      .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
      .rdFlag(rdFlag), .rdAddr(rdAddr), .rdDest(rdDest),
      .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
      .rs1Value(rs1Value), .rs1Rename(rs1Rename), .rs1Busy(rs1Busy),
      .rs2Value(rs2Value), .rs2Rename(rs2Rename), .rs2Busy(rs2Busy),
      .writeFlag(writeFlag), .robId(robId), .writeAddr(writeAddr), .writeValue(writeValue)
   );

   always #5 clockIn = ~clockIn;

   int checkCount = 0;
   int errorCount = 0;

   // Reference architectural state.
   logic [XLEN-1:0] mval  [NREG];
   logic            mbusy [NREG];
   logic [RW-1:0]   mtag  [NREG];

   // Stimulus, one entry per slot / commit port.
   logic            rf  [IW];
   logic [AW-1:0]   ra  [IW];
   logic [RW-1:0]   rd  [IW];
   logic [AW-1:0]   s1  [IW];
   logic [AW-1:0]   s2  [IW];
   logic            wf  [CW];
   logic [RW-1:0]   wid [CW];
   logic [AW-1:0]   wa  [CW];
   logic [XLEN-1:0] wv  [CW];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      for (int n = 0; n < NREG; n++) begin
         mval[n] = '0; mbusy[n] = 1'b0; mtag[n] = '0;
      end
   endtask

   task automatic idle();
      readyIn = 1'b1; clearIn = 1'b0;
      for (int i = 0; i < IW; i++) begin rf[i] = 0; ra[i] = 0; rd[i] = 0; s1[i] = 0; s2[i] = 0; end
      for (int j = 0; j < CW; j++) begin wf[j] = 0; wid[j] = 0; wa[j] = 0; wv[j] = 0; end
   endtask

   // Push stimulus arrays onto the DUT pins and let combinational reads settle.
   task automatic apply();
      for (int i = 0; i < IW; i++) begin
         rdFlag[i]            = rf[i];
         rdAddr[i*AW +: AW]   = ra[i];
         rdDest[i*RW +: RW]   = rd[i];
         rs1Addr[i*AW +: AW]  = s1[i];
         rs2Addr[i*AW +: AW]  = s2[i];
      end
      for (int j = 0; j < CW; j++) begin
         writeFlag[j]              = wf[j];
         robId[j*RW +: RW]         = wid[j];
         writeAddr[j*AW +: AW]     = wa[j];
         writeValue[j*XLEN +: XLEN] = wv[j];
      end
      #1;
   endtask

   // Expected read of register r as seen by slot i.
   task automatic expRead(input int i, input logic [AW-1:0] r,
                          output logic [XLEN-1:0] v, output logic b, output logic [RW-1:0] t);
      int hit, last;
      v = mval[r]; b = mbusy[r]; t = mtag[r];
      hit = -1; last = -1;
      for (int j = 0; j < CW; j++) begin
         if (wf[j] && wa[j] == r) begin
            last = j;
            if (mbusy[r] && wid[j] == mtag[r]) hit = j;
         end
      end
      if (hit >= 0) begin v = wv[hit]; b = 1'b0; end
      else if (last >= 0) v = wv[last];
      for (int k = 0; k < i; k++)
         if (rf[k] && ra[k] == r && r != 0) begin b = 1'b1; t = rd[k]; end
      if (r == 0) begin v = '0; b = 1'b0; t = '0; end
   endtask

   task automatic checkAll();
      logic [XLEN-1:0] v; logic b; logic [RW-1:0] t;
      for (int i = 0; i < IW; i++) begin
         expRead(i, s1[i], v, b, t);
         check($sformatf("s%0d_rs1Value", i), 64'(rs1Value[i*XLEN +: XLEN]), 64'(v));
         check($sformatf("s%0d_rs1Busy", i),  64'(rs1Busy[i]), 64'(b));
         check($sformatf("s%0d_rs1Rename", i), 64'(rs1Rename[i*RW +: RW]), 64'(t));
         expRead(i, s2[i], v, b, t);
         check($sformatf("s%0d_rs2Value", i), 64'(rs2Value[i*XLEN +: XLEN]), 64'(v));
         check($sformatf("s%0d_rs2Busy", i),  64'(rs2Busy[i]), 64'(b));
         check($sformatf("s%0d_rs2Rename", i), 64'(rs2Rename[i*RW +: RW]), 64'(t));
      end
   endtask

   // Clock edge: advance the model with the same stimulus, return on the falling edge.
   task automatic tick();
      @(posedge clockIn);
      if (clearIn) begin
         for (int n = 0; n < NREG; n++) mbusy[n] = 1'b0;
      end else if (readyIn) begin
         logic [RW-1:0] oldTag [NREG];
         for (int n = 0; n < NREG; n++) oldTag[n] = mtag[n];
         for (int j = 0; j < CW; j++)
            if (wf[j] && wa[j] != 0) begin
               mval[wa[j]] = wv[j];
               if (oldTag[wa[j]] == wid[j]) mbusy[wa[j]] = 1'b0;
            end
         for (int k = 0; k < IW; k++)
            if (rf[k] && ra[k] != 0) begin mbusy[ra[k]] = 1'b1; mtag[ra[k]] = rd[k]; end
      end
      @(negedge clockIn);
   endtask

   task automatic step();
      apply(); checkAll(); tick();
   endtask

   task automatic randomStim();
      readyIn = ($urandom_range(9) != 0);
      clearIn = ($urandom_range(19) == 0);
      for (int i = 0; i < IW; i++) begin
         rf[i] = $urandom_range(1); ra[i] = AW'($urandom_range(7)); rd[i] = RW'($urandom_range(15));
         s1[i] = AW'($urandom_range(7)); s2[i] = AW'($urandom_range(7));
      end
      for (int j = 0; j < CW; j++) begin
         wf[j] = $urandom_range(1); wa[j] = AW'($urandom_range(7));
         wid[j] = ($urandom_range(1) == 1) ? mtag[wa[j]] : RW'($urandom_range(15));
         wv[j] = $urandom;
      end
   endtask

   initial begin
      resetIn = 1'b0;
      modelReset();
      idle();
      apply();
      checkAll();
      @(negedge clockIn);
      resetIn = 1'b1;

      // Rename x5 to tag 3, then its commit resolves the read in the same cycle.
      idle(); rf[0] = 1; ra[0] = 5; rd[0] = 3; step();
      idle(); wf[0] = 1; wid[0] = 3; wa[0] = 5; wv[0] = 32'hDEAD; s1[0] = 5;
      apply();
      check("t2_bypassBusy", 64'(rs1Busy[0]), 64'd0);
      check("t2_bypassValue", 64'(rs1Value[XLEN-1:0]), 64'hDEAD);
      checkAll(); tick();
      idle(); s1[0] = 5; apply();
      check("t2_storedValue", 64'(rs1Value[XLEN-1:0]), 64'hDEAD);
      check("t2_storedBusy", 64'(rs1Busy[0]), 64'd0);
      tick();

      // Stale commit updates the value but leaves the newer rename pending.
      idle(); rf[0] = 1; ra[0] = 5; rd[0] = 3; step();
      idle(); rf[0] = 1; ra[0] = 5; rd[0] = 7; step();
      idle(); wf[0] = 1; wid[0] = 3; wa[0] = 5; wv[0] = 1; step();
      idle(); s1[0] = 5; apply();
      check("t3_value", 64'(rs1Value[XLEN-1:0]), 64'd1);
      check("t3_busy", 64'(rs1Busy[0]), 64'd1);
      check("t3_rename", 64'(rs1Rename[RW-1:0]), 64'd7);
      tick();

      // Intra-bundle dependency and same-rd collision.
      idle(); rf[0] = 1; ra[0] = 6; rd[0] = 2; rf[1] = 1; ra[1] = 6; rd[1] = 4; s1[1] = 6; s2[1] = 0;
      apply();
      check("t4_rs1Busy", 64'(rs1Busy[1]), 64'd1);
      check("t4_rs1Rename", 64'(rs1Rename[2*RW-1:RW]), 64'd2);
      check("t4_rs2Value", 64'(rs2Value[2*XLEN-1:XLEN]), 64'd0);
      check("t4_rs2Busy", 64'(rs2Busy[1]), 64'd0);
      checkAll(); tick();
      idle(); s1[0] = 6; apply();
      check("t4_youngestTag", 64'(rs1Rename[RW-1:0]), 64'd4);
      tick();

      // Flush drops busy and the concurrent commit.
      idle(); rf[0] = 1; ra[0] = 1; rd[0] = 8; rf[1] = 1; ra[1] = 2; rd[1] = 9; step();
      idle(); rf[0] = 1; ra[0] = 3; rd[0] = 10; rf[1] = 1; ra[1] = 4; rd[1] = 11; step();
      idle(); clearIn = 1; wf[0] = 1; wid[0] = 8; wa[0] = 1; wv[0] = 9; step();
      idle(); s1[0] = 1; s2[0] = 2; s1[1] = 3; s2[1] = 4; apply();
      check("t5_x1Value", 64'(rs1Value[XLEN-1:0]), 64'd0);
      check("t5_busyMask", 64'({rs1Busy, rs2Busy}), 64'd0);
      checkAll(); tick();

      // Stall holds state; commit to x0 is ignored.
      idle(); readyIn = 0; rf[0] = 1; ra[0] = 7; rd[0] = 5; wf[0] = 1; wa[0] = 5; wv[0] = 32'h55; step();
      idle(); s1[0] = 7; s2[0] = 5; apply();
      check("t6_stallBusy", 64'(rs1Busy[0]), 64'd0);
      check("t6_stallValue", 64'(rs2Value[XLEN-1:0]), 64'd1);
      tick();
      idle(); wf[0] = 1; wa[0] = 0; wv[0] = 32'hFF; step();
      idle(); s1[0] = 0; apply();
      check("t6_x0Value", 64'(rs1Value[XLEN-1:0]), 64'd0);
      tick();

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         randomStim();
         step();
      end

      // Ensure some registers are busy, then reset asynchronously mid-cycle.
      idle(); rf[0] = 1; ra[0] = 3; rd[0] = 6; rf[1] = 1; ra[1] = 4; rd[1] = 12; step();
      idle(); s1[0] = 3; s2[0] = 4; s1[1] = 2; s2[1] = 5;
      apply();
      #1 resetIn = 1'b0;
      modelReset();
      #1;
      check("t1_rs1Value", 64'(rs1Value), 64'd0);
      check("t1_rs2Value", 64'(rs2Value), 64'd0);
      check("t1_busy", 64'({rs1Busy, rs2Busy}), 64'd0);
      check("t1_rename", 64'({rs1Rename, rs2Rename}), 64'd0);
      checkAll();
      @(negedge clockIn);
      resetIn = 1'b1;

      for (int c = 0; c < 100; c++) begin
         randomStim();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
